// File: rtl/uart_mem_loader.sv
// uart_mem_loader: length-prefixed UART byte stream into a memory write port.
// Optional trailing checksum byte: define UART_MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter bit MSB_FIRST      = 1'b1,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uart_v,
  input  logic [7:0]        uart_d,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

  localparam logic [CW-1:0]     DEPTH_C = CW'(1) << ADDR_W;
  localparam logic [BW-1:0]     LAST_B  = BW'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_A  = '1;
  localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    ,
    S_CSUM
`endif
  } state_t;

  state_t            state;
  logic [BW-1:0]     byte_cnt;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W:0]   len_q;
  logic [7:0]        hold_q;
  logic              hold_v;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              in_v;
  logic [7:0]        in_d;
  logic [DATA_W-1:0] acc_nxt;
  logic [CW-1:0]     len_w;
  logic              last_b;

  // Byte source (held byte first) and the word being assembled
  always_comb begin
    in_v = hold_v | uart_v;
    in_d = hold_v ? hold_q : uart_d;
    if (MSB_FIRST) begin
      acc_nxt = (acc << 8) | DATA_W'(in_d);
    end else begin
      acc_nxt = (acc >> 8) | (DATA_W'(in_d) << (DATA_W - 8));
    end
    len_w  = CW'(acc_nxt);
    last_b = (byte_cnt == LAST_B);
  end

  // Download controller with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_wa     <= '0;
      mem_wd     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      byte_cnt   <= '0;
      len_q      <= '0;
      acc        <= '0;
      hold_q     <= '0;
      hold_v     <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
            acc        <= '0;
            hold_v     <= 1'b0;
            busy       <= 1'b1;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            if (CLEAR_ON_START) begin
              state  <= S_CLEAR;
              mem_we <= 1'b1;
              mem_wa <= '0;
              mem_wd <= '0;
            end else begin
              state <= S_LEN;
            end
          end
        end

        S_CLEAR: begin
          mem_we <= 1'b1;
          if (mem_wa == LAST_A) begin
            mem_we <= 1'b0;
            mem_wa <= '0;
            state  <= S_LEN;
          end else begin
            mem_wa <= mem_wa + ADDR_W'(1);
          end
          if (uart_v) begin
            if (hold_v) begin
              state  <= S_ERR;
              err    <= 1'b1;
              busy   <= 1'b0;
              mem_we <= 1'b0;
              mem_wa <= mem_wa;
              hold_v <= 1'b0;
            end else begin
              hold_q <= uart_d;
              hold_v <= 1'b1;
            end
          end
        end

        S_LEN: begin
          if (hold_v) begin
            hold_v <= uart_v;
            hold_q <= uart_d;
          end
          if (in_v) begin
            acc <= acc_nxt;
            if (last_b) begin
              byte_cnt <= '0;
              len_q    <= len_w[ADDR_W:0];
              if (len_w == '0) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state  <= S_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
                hold_v <= 1'b0;
`endif
              end else if (len_w > DEPTH_C) begin
                state  <= S_ERR;
                err    <= 1'b1;
                busy   <= 1'b0;
                hold_v <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end

        S_DATA: begin
          if (hold_v) begin
            hold_v <= uart_v;
            hold_q <= uart_d;
          end
          if (in_v) begin
            acc <= acc_nxt;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q + in_d;
`endif
            if (last_b) begin
              byte_cnt   <= '0;
              mem_we     <= 1'b1;
              mem_wa     <= word_count[ADDR_W-1:0];
              mem_wd     <= acc_nxt;
              word_count <= word_count + WC_ONE;
              if (word_count + WC_ONE == len_q) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state  <= S_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
                hold_v <= 1'b0;
`endif
              end
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (hold_v) begin
            hold_v <= uart_v;
            hold_q <= uart_d;
          end
          if (in_v) begin
            busy   <= 1'b0;
            hold_v <= 1'b0;
            if (in_d == csum_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed and randomized downloads into two loaders
// (big-endian with clear sweep, little-endian without).
`timescale 1ns/1ps
module tb_uart_mem_loader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, uv;
  logic [7:0]    ud;
  logic          we, busy, done, err;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW:0]   wc;

  logic          rst2, start2, uv2;
  logic [7:0]    ud2;
  logic          we2, busy2, done2, err2;
  logic [AW-1:0] wa2;
  logic [DW-1:0] wd2;
  logic [AW:0]   wc2;

  uart_mem_loader #(
    .DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b1), .CLEAR_ON_START(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .uart_v(uv), .uart_d(ud),
    .mem_we(we), .mem_wa(wa), .mem_wd(wd), .busy(busy), .done(done),
    .err(err), .word_count(wc)
  );

  uart_mem_loader #(
    .DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b0), .CLEAR_ON_START(1'b0)
  ) u_dut_lsb (
    .clk(clk), .rst(rst2), .start(start2), .uart_v(uv2), .uart_d(ud2),
    .mem_we(we2), .mem_wa(wa2), .mem_wd(wd2), .busy(busy2), .done(done2),
    .err(err2), .word_count(wc2)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    bit          exp_done;
    bit          exp_err;
    int          exp_wc;
  } vec_t;

  wr_t wq[$];
  wr_t wq2[$];

  int checks = 0;
  int errors = 0;

  // Record every memory write seen on either instance
  always @(negedge clk) begin
    if (we)  wq.push_back({wa, wd});
    if (we2) wq2.push_back({wa2, wd2});
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] b);
    if (sel == 0) begin uv = 1'b1; ud = b; end
    else begin uv2 = 1'b1; ud2 = b; end
    tick();
    if (sel == 0) uv = 1'b0;
    else uv2 = 1'b0;
  endtask

  task automatic send_g(input int sel, input logic [7:0] b);
    send(sel, b);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_csum(input int sel, input logic [7:0] s);
    if (CSUM_EN) send(sel, s);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start = 1'b1;
    else start2 = 1'b1;
    tick();
    if (sel == 0) start = 1'b0;
    else start2 = 1'b0;
  endtask

  task automatic wait_end(input int sel, input int max);
    int n = 0;
    while (!(sel == 0 ? (done || err) : (done2 || err2)) && n < max) begin
      tick();
      n++;
    end
    chk("timeout", (n >= max) ? 1 : 0, 0);
  endtask

  function automatic logic [7:0] bsum(input logic [31:0] w);
    return 8'((w >> 24) + (w >> 16) + (w >> 8) + w);
  endfunction

  // One full download on the big-endian instance, checked against a model
  task automatic run_dl(input string tag, input logic [31:0] len,
                        input bit exp_done, input bit exp_err,
                        input int exp_wc);
    logic [31:0] words[$];
    wr_t         exp_q[$];
    logic [31:0] w;
    logic [7:0]  sum;
    bit          m_err;
    int          nw;
    m_err = (len > 32'(DEPTH));
    nw    = m_err ? 0 : int'(len);
    sum   = 8'h00;
    wq.delete();
    pulse_start(0);
    repeat (DEPTH + 2) tick();
    chk({tag, "_clr"}, wq.size(), DEPTH);
    wq.delete();
    for (int i = 3; i >= 0; i--) send_g(0, len[8*i +: 8]);
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      words.push_back(w);
      sum = sum + bsum(w);
      for (int j = 3; j >= 0; j--) send_g(0, w[8*j +: 8]);
    end
    if (!m_err) send_csum(0, sum);
    wait_end(0, 100);
    tick();
    tick();
    for (int i = 0; i < nw; i++) exp_q.push_back({AW'(i), words[i]});
    chk({tag, "_nwr"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      chk({tag, "_wr"}, wq[i], exp_q[i]);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_wc"}, wc, exp_wc);
    chk({tag, "_busy"}, busy, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int L;
    vecs[0] = '{32'd2,          1'b1, 1'b0, 2};
    vecs[1] = '{32'd0,          1'b1, 1'b0, 0};
    vecs[2] = '{32'd16,         1'b1, 1'b0, 16};
    vecs[3] = '{32'd17,         1'b0, 1'b1, 0};
    vecs[4] = '{32'd1,          1'b1, 1'b0, 1};
    vecs[5] = '{32'hFFFF_FFFF,  1'b0, 1'b1, 0};
    vecs[6] = '{32'h0000_0100,  1'b0, 1'b1, 0};

    rst = 1'b1; start = 1'b0; uv = 1'b0; ud = 8'h00;
    rst2 = 1'b1; start2 = 1'b0; uv2 = 1'b0; ud2 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_out", {we, wa, wd, busy, done, err, wc}, 0);
    chk("rst_out2", {we2, wa2, wd2, busy2, done2, err2, wc2}, 0);

    // Clear sweep
    pulse_start(0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("sweep", {we, wa, (wd == 0), busy}, {1'b1, AW'(i), 1'b1, 1'b1});
    end
    @(negedge clk);
    chk("sweep_end", {we, busy}, 2'b01);
    tick();
    wq.delete();

    // Two-word download with exact write timing
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h02);
    send(0, 8'hDE); send(0, 8'hAD); send(0, 8'hBE);
    @(negedge clk);
    chk("w0_early", we, 0);
    send(0, 8'hEF);
    @(negedge clk);
    chk("w0", {we, wa, wd}, {1'b1, 4'd0, 32'hDEADBEEF});
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h13);
    @(negedge clk);
    chk("w1", {we, wa, wd}, {1'b1, 4'd1, 32'h00000013});
    send_csum(0, bsum(32'hDEADBEEF) + bsum(32'h13));
    @(negedge clk);
    chk("dl2_end", {done, err, busy, wc}, {1'b1, 1'b0, 1'b0, 5'd2});
    tick();
    chk("dl2_nwr", wq.size(), 2);

    // Oversized length, then restart
    pulse_start(0);
    repeat (DEPTH + 2) tick();
    wq.delete();
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h11);
    @(negedge clk);
    chk("len17", {err, done, busy}, 3'b100);
    tick();
    chk("len17_nwr", wq.size(), 0);
    pulse_start(0);
    @(negedge clk);
    chk("restart", {err, we, wa, busy}, {1'b0, 1'b1, 4'd0, 1'b1});
    repeat (DEPTH + 2) tick();
    pulse_start(0);
    @(negedge clk);
    chk("start_busy", {we, busy}, 2'b01);
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    send_csum(0, 8'h00);
    @(negedge clk);
    chk("len0", {done, err, wc}, {1'b1, 1'b0, 5'd0});

    // One byte during the sweep becomes the length MSB
    pulse_start(0);
    repeat (4) tick();
    send(0, 8'h00);
    repeat (DEPTH) tick();
    wq.delete();
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h01);
    send(0, 8'hA5); send(0, 8'hA5); send(0, 8'h12); send(0, 8'h34);
    send_csum(0, bsum(32'hA5A51234));
    @(negedge clk);
    chk("hold1", {done, err, wc}, {1'b1, 1'b0, 5'd1});
    tick();
    chk("hold1_nwr", wq.size(), 1);
    if (wq.size() > 0) chk("hold1_wr", wq[0], {4'd0, 32'hA5A51234});

    // Two bytes during the sweep overrun the hold register
    pulse_start(0);
    repeat (3) tick();
    send(0, 8'h00);
    send(0, 8'h01);
    @(negedge clk);
    chk("overrun", {err, busy, we}, 3'b100);

    // Reset beats start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_wins", {busy, err, we}, 3'b000);

    // Little-endian instance, no sweep
    pulse_start(1);
    @(negedge clk);
    chk("lsb_start", {busy2, we2}, 2'b10);
    send(1, 8'h02); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    send(1, 8'hEF); send(1, 8'hBE); send(1, 8'hAD); send(1, 8'hDE);
    @(negedge clk);
    chk("lsb_w0", {we2, wa2, wd2}, {1'b1, 4'd0, 32'hDEADBEEF});
    send(1, 8'h11);
    send(1, 8'h22);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    @(negedge clk);
    chk("lsb_rst", {busy2, done2, err2, wc2}, 0);
    tick();
    chk("lsb_rst_nwr", wq2.size(), 1);
    wq2.delete();
    pulse_start(1);
    send(1, 8'h01); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    send(1, 8'h44); send(1, 8'h33); send(1, 8'h22); send(1, 8'h11);
    @(negedge clk);
    chk("lsb_w1", {we2, wa2, wd2}, {1'b1, 4'd0, 32'h11223344});
    send_csum(1, bsum(32'h11223344));
    wait_end(1, 20);
    @(negedge clk);
    chk("lsb_end", {done2, err2, wc2}, {1'b1, 1'b0, 5'd1});

    // Table of length boundaries
    for (int i = 0; i < 7; i++)
      run_dl($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_done,
             vecs[i].exp_err, vecs[i].exp_wc);

    // Randomized lengths and data
    for (int i = 0; i < 12; i++) begin
      L = $urandom_range(0, 20);
      run_dl($sformatf("rnd%0d", i), 32'(L), (L <= DEPTH), (L > DEPTH),
             (L <= DEPTH) ? L : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
